// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS control FSM driving the datapath strobes.
// Build option CTRL_EXC_EN: illegal instructions trap into HALT (exc=1) instead of acting as NOPs.
module mips_mc_ctrl #(
  parameter int FETCH_WAIT = 0,
  parameter int STATE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        Instruction,
  input  logic               HitDev,
  output logic               RegDst,
  output logic               RegWr,
  output logic [1:0]         ExtOp,
  output logic [1:0]         nPC_sel,
  output logic [3:0]         ALUctr,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               MemWr,
  output logic               PrWE,
  output logic               lb_sel,
  output logic               sb_sel,
  output logic               j_sel,
  output logic               jal_sel,
  output logic               jalr_en,
  output logic               IRWr,
  output logic               PCWr,
  output logic               Din_sel,
  output logic               exc,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE, S_FETCH, S_DCD, S_EXE, S_WB, S_MA, S_MW, S_MR, S_LWB, S_BR, S_JMP
`ifdef CTRL_EXC_EN
    , S_HALT
`endif
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       hit_q;

  logic [5:0] op, fn;
  logic       is_r, i_addu, i_subu, i_slt, i_ori, i_lui, i_lw, i_lb, i_sw, i_sb;
  logic       i_beq, i_j, i_jal, i_jr, i_jalr, is_alu, is_mem, is_ld, is_jmp;
  logic [3:0] alu_op;
  logic       unused_bits;

  assign op          = Instruction[31:26];
  assign fn          = Instruction[5:0];
  assign unused_bits = ^Instruction[25:6];
  assign is_r        = (op == 6'h00);
  assign i_addu      = is_r && (fn == 6'h21);
  assign i_subu      = is_r && (fn == 6'h23);
  assign i_slt       = is_r && (fn == 6'h2A);
  assign i_jr        = is_r && (fn == 6'h08);
  assign i_jalr      = is_r && (fn == 6'h09);
  assign i_ori       = (op == 6'h0D);
  assign i_lui       = (op == 6'h0F);
  assign i_lw        = (op == 6'h23);
  assign i_lb        = (op == 6'h20);
  assign i_sw        = (op == 6'h2B);
  assign i_sb        = (op == 6'h28);
  assign i_beq       = (op == 6'h04);
  assign i_j         = (op == 6'h02);
  assign i_jal       = (op == 6'h03);
  assign is_alu      = i_addu | i_subu | i_slt | i_ori | i_lui;
  assign is_ld       = i_lw | i_lb;
  assign is_mem      = is_ld | i_sw | i_sb;
  assign is_jmp      = i_j | i_jal | i_jr | i_jalr;
  // lui relies on rs=$0, so OR-ing the shifted immediate yields it unchanged
  assign alu_op      = i_subu ? 4'b0001 : i_slt ? 4'b0011 : (i_ori | i_lui) ? 4'b0010 : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      hit_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: begin
          if (cnt == 4'(FETCH_WAIT)) begin
            cnt   <= 4'd0;
            state <= S_DCD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DCD: begin
          if (is_alu)      state <= S_EXE;
          else if (is_mem) state <= S_MA;
          else if (i_beq)  state <= S_BR;
          else if (is_jmp) state <= S_JMP;
          else begin
`ifdef CTRL_EXC_EN
            state <= S_HALT;
`else
            state <= S_FETCH;
`endif
          end
        end
        S_EXE: state <= S_WB;
        S_MA:  state <= is_ld ? S_MR : S_MW;
        S_MR: begin
          hit_q <= HitDev;
          state <= S_LWB;
        end
        S_WB, S_MW, S_LWB, S_BR, S_JMP: state <= S_FETCH;
`ifdef CTRL_EXC_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    RegDst = 1'b0; RegWr = 1'b0; ExtOp = 2'b00; nPC_sel = 2'b00; ALUctr = 4'b0000;
    ALUSrc = 1'b0; MemtoReg = 1'b0; MemWr = 1'b0; PrWE = 1'b0; lb_sel = 1'b0;
    sb_sel = 1'b0; j_sel = 1'b0; jal_sel = 1'b0; jalr_en = 1'b0; IRWr = 1'b0;
    PCWr = 1'b0; Din_sel = 1'b0; exc = 1'b0;
    case (state)
      S_FETCH: begin
        IRWr = (cnt == 4'(FETCH_WAIT));
        PCWr = (cnt == 4'(FETCH_WAIT));
      end
      S_EXE, S_WB: begin
        ALUctr = alu_op;
        ALUSrc = i_ori | i_lui;
        ExtOp  = i_lui ? 2'b10 : 2'b00;
        RegWr  = (state == S_WB);
        RegDst = (state == S_WB) && is_r;
      end
      S_MA: begin
        ALUSrc = 1'b1;
        ExtOp  = 2'b01;
      end
      S_MW: begin
        MemWr  = !HitDev;
        PrWE   = HitDev;
        sb_sel = i_sb;
      end
      S_LWB: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
        lb_sel   = i_lb;
        Din_sel  = hit_q;
      end
      S_BR: begin
        ALUctr  = 4'b0001;
        PCWr    = 1'b1;
        nPC_sel = 2'b01;
      end
      S_JMP: begin
        PCWr    = 1'b1;
        nPC_sel = (i_jr | i_jalr) ? 2'b11 : 2'b10;
        j_sel   = i_j | i_jal;
        RegWr   = i_jal | i_jalr;
        jal_sel = i_jal | i_jalr;
        jalr_en = i_jalr;
        RegDst  = i_jalr;
      end
`ifdef CTRL_EXC_EN
      S_HALT: exc = 1'b1;
`endif
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath (IFU, IR, GPR, ALU, EXT, DM, A/B/ALUout/busW delay registers, processor-bridge read mux).
- Decodes the IR output and drives every datapath control strobe, one state per cycle.
- Sits beside the datapath in the CPU top. Output port names match the datapath inputs so the top wires them 1:1.

Parameters:
FETCH_WAIT, 0, extra wait cycles held in FETCH before IR/PC update (slow IM); 0..15
STATE_W, 4, width of state register and dbg_state port

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-low
Instruction  in  32  IR output from datapath
HitDev  in  1  bridge: current ALUout address is a device (not DM)
RegDst  out  1  0=rt, 1=rd write select
RegWr  out  1  GPR write enable
ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
nPC_sel  out  2  00 PC+4, 01 beq, 10 j/jal, 11 jr/jalr
ALUctr  out  4  0000 add, 0001 sub, 0010 or, 0011 slt
ALUSrc  out  1  0=B, 1=imm32
MemtoReg  out  1  0=ALU, 1=DM
MemWr  out  1  DM write enable
PrWE  out  1  device write enable (store to device)
lb_sel, sb_sel  out  1  byte load/store
j_sel, jal_sel, jalr_en  out  1  jump target/link controls
IRWr, PCWr  out  1  IR and PC write enables
Din_sel  out  1  1=write-back from PrRD
exc  out  1  illegal-instruction flag (see option)
dbg_state  out  STATE_W  current state

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, latched HitDev=0. In IDLE all outputs are 0, exc=0.
- First clk after release: IDLE->FETCH.
- Outputs: combinational decode of state plus Instruction opcode/funct. Instruction is stable from DCD until the next FETCH update.
- FETCH: counter runs 0..FETCH_WAIT. IRWr=PCWr=1, nPC_sel=00 only on the final count; then ->DCD.
- DCD: no strobes; A/B registers load. Next state by opcode:
  - addu/subu/slt/ori/lui ->EXE
  - lw/lb/sw/sb ->MA
  - beq ->BR
  - j/jal/jr/jalr ->JMP
  - other ->FETCH (NOP)
- EXE: ALUctr per funct/op. ALUSrc=1 and ExtOp=00 for ori; ExtOp=10 for lui. ->WB.
- WB: RegWr=1, RegDst=1 for R-type, else 0; ALU controls held. ->FETCH.
- MA: ALUSrc=1, ExtOp=01, ALUctr=add. ->MR for loads, ->MW for stores.
- MW: HitDev=0 gives MemWr=1; HitDev=1 gives PrWE=1, MemWr=0. sb_sel=1 for sb. ->FETCH.
- MR: HitDev latched. ->LWB.
- LWB: RegWr=1, RegDst=0, MemtoReg=1, lb_sel=1 for lb, Din_sel=latched HitDev. ->FETCH.
- BR: ALUctr=sub, PCWr=1, nPC_sel=01 (IFU uses zero). ->FETCH.
- JMP:
  - PCWr=1; nPC_sel=10 with j_sel=1 for j/jal, nPC_sel=11 for jr/jalr.
  - jal: RegWr=1, jal_sel=1 (link to $31).
  - jalr: RegWr=1, jal_sel=1, jalr_en=1, RegDst=1.
  - ->FETCH.
- At most one of MemWr/PrWE is high in any cycle. RegWr and MemWr are never high together.
- Reset mid-instruction aborts immediately; no partial write strobe survives the reset edge.

Optional Feature:
- Macro: CTRL_EXC_EN.
- Defined: unrecognised opcode/funct in DCD ->HALT. HALT asserts exc=1 and all strobes 0, and is left only by reset.
- Undefined: no HALT state; illegal ops are NOPs (DCD->FETCH); exc tied 0.

Test Plan:
- Reset low, then release -> IDLE for 1 cycle, FETCH next; IRWr=PCWr=1 exactly one cycle; dbg_state sequence IDLE,FETCH,DCD.
- addu $3,$1,$2 (0x00221821), FETCH_WAIT=0 -> 4 cycles F,D,EXE,WB; WB has RegWr=1, RegDst=1, ALUctr=0000.
- lw with HitDev=1 in MR -> LWB: Din_sel=1, MemtoReg=1, RegWr=1. sw with HitDev=1 -> PrWE=1, MemWr=0.
- beq (0x10220003) -> BR state: PCWr=1, nPC_sel=01, ALUctr=0001; 3 cycles total.
- jalr $31,$5 -> JMP: nPC_sel=11, RegWr=1, jal_sel=1, jalr_en=1. FETCH_WAIT=2 -> FETCH lasts 3 cycles, strobes only in the last.
- Opcode 0x3F: CTRL_EXC_EN gives HALT, exc=1, PCWr=0 until reset; without it, FETCH follows DCD and exc=0.
